// File: rtl/pipe_stage_chain_if.sv
`timescale 1ns/1ps
// Handshake bundle for pipe_stage_chain.
// The upstream producer, the downstream consumer and the debug controls share one bundle.
// master: the side that drives the chain (producer, consumer and debug unit).
// slave:  the chain itself.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              i_pipeline_enable;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [OCC_W-1:0]  o_occupancy;
    logic              o_halt;

    modport master (
        output i_pipeline_enable, i_flush, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_occupancy, o_halt
    );

    modport slave (
        input  i_pipeline_enable, i_flush, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_occupancy, o_halt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
`timescale 1ns/1ps
// Elastic register chain: carries an opaque payload through STAGES registers
// with valid/ready handshake, bubble collapsing, flush, debug freeze, sticky
// halt capture and an occupancy count. State updates on the falling clock edge.
// Ports: i_clock, i_reset (async, active-high) plus the handshake bundle
// (enable, flush, upstream valid/ready/data, downstream valid/ready/data,
// occupancy, halt) on the slave modport of pipe_stage_chain_if.
module pipe_stage_chain #(
    parameter int DATA_W   = 32,
    parameter int STAGES   = 2,
    parameter int HALT_BIT = 0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    pipe_stage_chain_if.slave    bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [DATA_W-1:0] d [STAGES];
    logic              halt;

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] slot;
    logic              run;
    logic              accept;
    logic [OCC_W-1:0]  occ;

    // Advance terms resolve from the output side backwards, so a stage can
    // take a word in the same edge its downstream neighbour moves on. This
    // is what closes bubbles and gives full throughput.
    always_comb begin
        adv  = '0;
        slot = '0;
        adv[STAGES-1]  = v[STAGES-1] & bus.i_ready;
        slot[STAGES-1] = !v[STAGES-1] | adv[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k]  = v[k] & slot[k+1];
            slot[k] = !v[k] | adv[k];
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ = occ + OCC_W'(v[k]);
        end
    end

    assign run             = bus.i_pipeline_enable & !bus.i_flush;
    assign bus.o_ready     = run & !halt & slot[0];
    assign bus.o_valid     = v[STAGES-1] & run;
    assign bus.o_data      = d[STAGES-1];
    assign bus.o_occupancy = occ;
    assign bus.o_halt      = halt;
    assign accept          = bus.i_valid & bus.o_ready;

    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            v    <= '0;
            halt <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else if (bus.i_pipeline_enable) begin
            if (bus.i_flush) begin
                // Payload is held; only the valid bits are squashed.
                v <= '0;
            end else begin
                if (accept) begin
                    d[0] <= bus.i_data;
                    v[0] <= 1'b1;
                end else if (adv[0]) begin
                    v[0] <= 1'b0;
                end
                for (int k = 1; k < STAGES; k++) begin
                    if (adv[k-1]) begin
                        d[k] <= d[k-1];
                        v[k] <= 1'b1;
                    end else if (adv[k]) begin
                        v[k] <= 1'b0;
                    end
                end
                if (accept && bus.i_data[HALT_BIT]) begin
                    halt <= 1'b1;
                end
            end
        end
    end
endmodule
